// File: rtl/quad_pkg.sv
// Shared quadrature constants: Gray phase encoding and the emulator FSM states.
// The decoder imports the same package so both ends agree on the A/B sequence.
package quad_pkg;

    localparam logic [1:0] PH0 = 2'b00;
    localparam logic [1:0] PH1 = 2'b10;
    localparam logic [1:0] PH2 = 2'b11;
    localparam logic [1:0] PH3 = 2'b01;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One Gray step of the {a,b} pair; up walks PH0->PH1->PH2->PH3->PH0.
    function automatic logic [1:0] phase_step(input logic [1:0] ph, input logic up);
        logic [1:0] nxt;
        nxt = PH0;
        case (ph)
            PH0: nxt = up ? PH1 : PH3;
            PH1: nxt = up ? PH2 : PH0;
            PH2: nxt = up ? PH3 : PH1;
            PH3: nxt = up ? PH0 : PH2;
            default: nxt = PH0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quadrature_encoder_emulator_step_timer.sv
// Loadable down-counter; o_zero flags terminal count. Load wins over decrement,
// and the count parks at zero rather than wrapping.
module step_timer #(
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_load,
    input  logic [PERIOD_WIDTH-1:0] i_load_val,
    input  logic                    i_dec,
    output logic                    o_zero
);

    logic [PERIOD_WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - PERIOD_WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/quadrature_encoder_emulator.sv
// Drives quadrature A/B from the current emulated count to a commanded signed target,
// one edge every clamped step_period clocks; accepts a new command only while idle.
module quadrature_encoder_emulator
    import quad_pkg::*;
#(
    parameter int POS_WIDTH    = 32,
    parameter int PERIOD_WIDTH = 16,
    parameter int MIN_PERIOD   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [POS_WIDTH-1:0] target,
    input  logic [PERIOD_WIDTH-1:0]     step_period,
    input  logic                        target_valid,
    output logic                        target_ready,
    input  logic                        halt,
    output logic                        a,
    output logic                        b,
    output logic signed [POS_WIDTH-1:0] position,
    output logic                        direction,
    output logic                        busy
);

    localparam logic [PERIOD_WIDTH-1:0] MIN_P = PERIOD_WIDTH'(MIN_PERIOD);

    state_t                      r_state;
    state_t                      w_state_next;
    logic [1:0]                  r_phase;
    logic signed [POS_WIDTH-1:0] r_pos;
    logic signed [POS_WIDTH-1:0] r_target;
    logic [PERIOD_WIDTH-1:0]     r_period;
    logic                        r_dir;

    logic [PERIOD_WIDTH-1:0]     w_period_clamped;
    logic [PERIOD_WIDTH-1:0]     w_load_val;
    logic                        w_accept;
    logic                        w_emit;
    logic                        w_load;
    logic                        w_dec;
    logic                        w_zero;
    logic                        w_at_target;

    assign w_period_clamped = (step_period < MIN_P) ? MIN_P : step_period;
    assign w_at_target      = (r_pos == r_target);

    step_timer #(
        .PERIOD_WIDTH (PERIOD_WIDTH)
    ) u_step_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Halt outranks arrival, arrival outranks emitting, so a halted move never steps.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_emit       = 1'b0;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        w_load_val   = r_period - PERIOD_WIDTH'(1);
        case (r_state)
            IDLE: begin
                if (target_valid) begin
                    w_accept     = 1'b1;
                    w_load       = 1'b1;
                    w_load_val   = w_period_clamped - PERIOD_WIDTH'(1);
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (halt) begin
                    w_state_next = IDLE;
                end else if (w_at_target) begin
                    w_state_next = IDLE;
                end else if (w_zero) begin
                    w_emit = 1'b1;
                    w_load = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase  <= PH0;
            r_pos    <= '0;
            r_target <= '0;
            r_period <= MIN_P;
            r_dir    <= 1'b1;
        end else begin
            if (w_accept) begin
                r_target <= target;
                r_period <= w_period_clamped;
                r_dir    <= (target >= r_pos);
            end
            if (w_emit) begin
                r_phase <= phase_step(r_phase, r_dir);
                r_pos   <= r_dir ? (r_pos + POS_WIDTH'(1)) : (r_pos - POS_WIDTH'(1));
            end
        end
    end

    assign a            = r_phase[1];
    assign b            = r_phase[0];
    assign position     = r_pos;
    assign direction    = r_dir;
    assign busy         = (r_state == RUN);
    assign target_ready = (r_state == IDLE);

endmodule

// File: tb/tb_quadrature_encoder_emulator.sv
// Bench: moves the emulator through directed and random commands, decoding A/B independently.
module tb_quadrature_encoder_emulator;

    localparam int MINP = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic signed [31:0] target = '0;
    logic [15:0]        step_period = '0;
    logic               target_valid = 1'b0;
    logic               halt = 1'b0;
    logic               target_ready;
    logic               a;
    logic               b;
    logic signed [31:0] position;
    logic               direction;
    logic               busy;

    quadrature_encoder_emulator #(
        .POS_WIDTH    (32),
        .PERIOD_WIDTH (16),
        .MIN_PERIOD   (MINP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .target       (target),
        .step_period  (step_period),
        .target_valid (target_valid),
        .target_ready (target_ready),
        .halt         (halt),
        .a            (a),
        .b            (b),
        .position     (position),
        .direction    (direction),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic rst_q = 1'b1;
    int   dec_pos = 0;
    int   illegal = 0;
    int   dstep;
    int   edge_cyc[$];
    logic [1:0] prev_ab = 2'b00;
    int   mpos = 0;

    always @(posedge clk) cyc++;
    always @(posedge clk) rst_q <= reset;

    function automatic int ph_idx(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] ab_of(input int p);
        int idx;
        idx = ((p % 4) + 4) % 4;
        case (idx)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    // Reference decoder: counts Gray steps on a/b, resynced whenever reset was sampled.
    always @(negedge clk) begin
        if (rst_q) begin
            dec_pos = 0;
            prev_ab = {a, b};
        end else if ({a, b} != prev_ab) begin
            dstep = (ph_idx({a, b}) - ph_idx(prev_ab)) & 3;
            if (dstep == 1) dec_pos++;
            else if (dstep == 3) dec_pos--;
            else illegal++;
            edge_cyc.push_back(cyc);
            prev_ab = {a, b};
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        mpos = 0;
        tick();
    endtask

    task automatic issue(input int tgt, input int per, output int t0);
        int k;
        for (k = 0; k < 50 && !target_ready; k++) tick();
        chk("ready_before_cmd", target_ready, 1);
        edge_cyc.delete();
        target       = tgt;
        step_period  = 16'(per);
        target_valid = 1'b1;
        tick();
        t0           = cyc;
        target_valid = 1'b0;
        chk("busy_on_accept", busy, 1);
        chk("ready_on_accept", target_ready, 0);
        chk("dir_on_accept", direction, (tgt >= mpos) ? 1 : 0);
    endtask

    task automatic do_move(input int tgt, input int per, input bit pulse);
        int p, n, t0, k, bad;
        bit done;
        p = (per < MINP) ? MINP : per;
        n = (tgt >= mpos) ? (tgt - mpos) : (mpos - tgt);
        issue(tgt, per, t0);
        done = 1'b0;
        for (k = 0; k < n * p + 20 && !done; k++) begin
            if (pulse && n >= 2 && k == p + 1) begin
                target       = tgt + 5;
                target_valid = 1'b1;
            end else begin
                target_valid = 1'b0;
            end
            tick();
            if (!busy) done = 1'b1;
        end
        target_valid = 1'b0;
        chk("move_done", done, 1);
        chk("end_cycle", cyc, t0 + n * p + 1);
        chk("edge_count", edge_cyc.size(), n);
        if (n > 0) chk("first_edge", edge_cyc[0], t0 + p);
        bad = 0;
        for (int i = 1; i < edge_cyc.size(); i++)
            if (edge_cyc[i] - edge_cyc[i-1] != p) bad++;
        chk("bad_gaps", bad, 0);
        mpos = tgt;
        chk("position", position, mpos);
        chk("decoded_pos", dec_pos, mpos);
        chk("ab_phase", {a, b}, ab_of(mpos));
        chk("illegal_steps", illegal, 0);
        chk("ready_after", target_ready, 1);
    endtask

    initial begin
        int t0, k, tgt, per;

        do_reset();
        chk("rst_a", a, 0);
        chk("rst_b", b, 0);
        chk("rst_pos", position, 0);
        chk("rst_dir", direction, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ready", target_ready, 1);

        do_move(8, 4, 1'b0);
        do_move(-3, 10, 1'b0);
        do_move(2, 1, 1'b0);
        do_move(-1, 0, 1'b0);
        do_move(-1, 6, 1'b0);
        do_move(-12, 4, 1'b1);

        // Halt one cycle after the seventh edge.
        do_reset();
        issue(100, 5, t0);
        for (k = 0; k < 200 && edge_cyc.size() < 7; k++) tick();
        chk("halt_reach7", edge_cyc.size(), 7);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("halt_ready", target_ready, 1);
        chk("halt_busy", busy, 0);
        chk("halt_pos", position, 7);
        for (k = 0; k < 12; k++) tick();
        chk("halt_frozen_edges", edge_cyc.size(), 7);
        chk("halt_frozen_ab", {a, b}, ab_of(7));
        mpos = 7;
        do_move(10, 5, 1'b0);

        // Reset in the middle of a move.
        issue(-30, 4, t0);
        for (k = 0; k < 100 && edge_cyc.size() < 3; k++) tick();
        reset = 1'b1;
        tick();
        chk("midrst_a", a, 0);
        chk("midrst_b", b, 0);
        chk("midrst_pos", position, 0);
        chk("midrst_ready", target_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_dir", direction, 1);
        reset = 1'b0;
        mpos = 0;
        tick();

        for (int r = 0; r < 10; r++) begin
            tgt = int'($urandom_range(0, 40)) - 20;
            per = int'($urandom_range(0, 8));
            do_move(tgt, per, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
